uart_rx_8n1: RTL
================

Name: uart_rx_8n1

Overview:
UART receiver for 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity) on the serial link carrying nonce/block data into the SHA256 hasher. Runs directly on the 50 MHz system clock and times bits with an internal counter; it does not use a divided baud clock. Each accepted byte is presented on a parallel bus with a 1-cycle valid strobe for the downstream message-assembly logic.

Parameters:
CLKS_PER_BIT, 13'd5208, system clocks per bit (50 MHz / 9600 baud); set to 13'd8 for simulation; legal range 4..8191
HALF_BIT, CLKS_PER_BIT/2, clocks from detected start edge to start-bit mid-point check

Ports:
ClkIn  input  1  system clock, 50 MHz
Reset  input  1  asynchronous, active-low reset
En  input  1  receiver enable; low = synchronous abort to IDLE, counters cleared
Rx  input  1  asynchronous serial line, idle high
DataOut  output  8  last correctly framed byte; held until next good frame
DataValid  output  1  1-cycle pulse, DataOut updated same cycle
FrameErr  output  1  1-cycle pulse, stop bit sampled low
Busy  output  1  high in any state other than IDLE

Behaviour:
- One clock, ClkIn; reset asynchronous, active-low, on port Reset. All flops asynchronously reset.
- Reset values: DataOut=8'h00, DataValid=0, FrameErr=0, Busy=0, state=IDLE, bit counter=0, timer=0, Rx synchroniser flops=1 (line idle).
- Rx passes through a 2-flop synchroniser; rx_s = second stage. Edge detection uses a third flop, rx_d.
- Timer: 13-bit down counter. Bit index: 3-bit counter.
- IDLE: on rx_d=1 and rx_s=0 (falling edge) with En=1, go to START and load timer with HALF_BIT-1.
- START: at timer==0, sample rx_s. If 0, go to DATA, load timer with CLKS_PER_BIT-1, bit index=0. If 1, treat as a glitch: go to IDLE, no pulse.
- DATA: at timer==0, shift rx_s into the shift register MSB side (LSB-first on the wire) and reload the timer.
  - If bit index==7, go to STOP; otherwise increment the bit index.
- STOP: at timer==0, sample rx_s.
  - If 1: DataOut<=shift register, DataValid=1 for that one cycle.
  - If 0: FrameErr=1 for one cycle, DataOut unchanged.
  - Both cases go to IDLE.
- After a framing error, IDLE re-arms only on a fresh 1->0 edge. A held-low line (break) produces exactly one FrameErr and no further activity until Rx returns high.
- Sampling latency: start-bit centre is HALF_BIT clocks after the synchronised edge; each data bit is sampled CLKS_PER_BIT clocks later. DataValid is asserted HALF_BIT + 9*CLKS_PER_BIT clocks after the synchronised edge, to within 1 cycle.
- En=0 in any state: next cycle state=IDLE, timer=0, no DataValid/FrameErr. DataOut is retained.
- Reset asserted mid-frame: immediate return to the reset values listed above. After release, the receiver waits for a new falling edge.
- DataValid and FrameErr are never high in the same cycle. Busy is registered and equals (state!=IDLE).

Decomposition:
- Shared package uart_pkg: state encoding (IDLE, START, DATA, STOP as 2-bit localparams); CLKS_PER_BIT_9600=13'd5208; CLKS_PER_BIT_SIM=13'd8. The package is to be reused by the matching transmitter.
- One sub-module is natural: sync_2ff (2-flop synchroniser with reset value parameter, reset value 1 here). Timer and FSM stay in uart_rx_8n1.

Test Plan:
- CLKS_PER_BIT=8; send 8'hA5 frame with 8-clock bits -> one DataValid pulse, DataOut=8'hA5, FrameErr never high, Busy low after the frame.
- Back-to-back frames 8'h00 then 8'hFF with no idle gap -> two DataValid pulses, DataOut values 8'h00 then 8'hFF, no FrameErr.
- Low glitch of 2 clocks on idle Rx -> START entered, aborted at mid-bit check; no DataValid/FrameErr; Busy returns to 0.
- Frame 8'h3C with stop bit forced low, then Rx held low 40 clocks -> exactly one FrameErr pulse; DataOut keeps its previous value; no activity until Rx returns high, after which a following 8'h55 frame is received correctly.
- Reset pulsed low during data bit 4 of 8'h81, then 8'h81 resent -> no output from the aborted frame; the second frame gives DataOut=8'h81.
- En dropped for 1 cycle mid-frame -> state=IDLE next cycle, no pulses; a subsequent 8'h7E frame with En=1 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes and bit timing constants.
// Used by both the 8N1 receiver and its matching transmitter.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [12:0] CLKS_PER_BIT_9600 = 13'd5208;
    localparam logic [12:0] CLKS_PER_BIT_SIM  = 13'd8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Reset value is a parameter so idle-high lines come up idle.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    // Two-stage metastability filter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver timed by a down counter on the system clock.
// Presents each good byte with a 1-cycle valid; bad stop gives FrameErr.
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter logic [12:0] CLKS_PER_BIT = CLKS_PER_BIT_9600
) (
    input  logic       ClkIn,
    input  logic       Reset,
    input  logic       En,
    input  logic       Rx,
    output logic [7:0] DataOut,
    output logic       DataValid,
    output logic       FrameErr,
    output logic       Busy
);

    localparam logic [12:0] HALF_BIT = CLKS_PER_BIT / 13'd2;
    localparam logic [12:0] HALF_M1  = HALF_BIT - 13'd1;
    localparam logic [12:0] FULL_M1  = CLKS_PER_BIT - 13'd1;

    logic        w_rx_s;
    logic        r_rx_d;
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [12:0] r_timer;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_ferr;
    logic        r_busy;

    logic w_fall;
    logic w_tick;
    logic w_ld_half;
    logic w_ld_full;
    logic w_bit_clr;
    logic w_bit_inc;
    logic w_shift;
    logic w_good;
    logic w_bad;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .i_clk  (ClkIn),
        .i_rst_n(Reset),
        .i_d    (Rx),
        .o_q    (w_rx_s)
    );

    assign w_fall = r_rx_d & ~w_rx_s;
    assign w_tick = (r_timer == 13'd0);

    // Delayed copy of the synchronised line for edge detection
    always_ff @(posedge ClkIn or negedge Reset) begin
        if (!Reset) r_rx_d <= 1'b1;
        else        r_rx_d <= w_rx_s;
    end

    // State register
    always_ff @(posedge ClkIn or negedge Reset) begin
        if (!Reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; disable forces IDLE from anywhere
    always_comb begin
        w_state_nxt = r_state;
        if (!En) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_fall) w_state_nxt = ST_START;
                ST_START: if (w_tick) w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
                ST_DATA:  if (w_tick && r_bit == 3'd7) w_state_nxt = ST_STOP;
                ST_STOP:  if (w_tick) w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Datapath controls decoded from state and timer
    always_comb begin
        w_ld_half = 1'b0;
        w_ld_full = 1'b0;
        w_bit_clr = 1'b0;
        w_bit_inc = 1'b0;
        w_shift   = 1'b0;
        w_good    = 1'b0;
        w_bad     = 1'b0;
        if (En) begin
            case (r_state)
                ST_IDLE: w_ld_half = w_fall;
                ST_START: begin
                    w_ld_full = w_tick & ~w_rx_s;
                    w_bit_clr = w_tick & ~w_rx_s;
                end
                ST_DATA: begin
                    w_ld_full = w_tick;
                    w_shift   = w_tick;
                    w_bit_inc = w_tick & (r_bit != 3'd7);
                end
                ST_STOP: begin
                    w_good = w_tick & w_rx_s;
                    w_bad  = w_tick & ~w_rx_s;
                end
                default: ;
            endcase
        end
    end

    // Timer, bit index, shift register and registered outputs
    always_ff @(posedge ClkIn or negedge Reset) begin
        if (!Reset) begin
            r_timer <= 13'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= w_good;
            r_ferr  <= w_bad;
            r_busy  <= (w_state_nxt != ST_IDLE);
            if (!En) begin
                r_timer <= 13'd0;
                r_bit   <= 3'd0;
            end else begin
                if (w_ld_half)
                    r_timer <= HALF_M1;
                else if (w_ld_full)
                    r_timer <= FULL_M1;
                else if (r_state != ST_IDLE && !w_tick)
                    r_timer <= r_timer - 13'd1;
                if (w_bit_clr)
                    r_bit <= 3'd0;
                else if (w_bit_inc)
                    r_bit <= r_bit + 3'd1;
            end
            if (w_shift)
                r_shift <= {w_rx_s, r_shift[7:1]};
            if (w_good)
                r_data <= r_shift;
        end
    end

    assign DataOut   = r_data;
    assign DataValid = r_valid;
    assign FrameErr  = r_ferr;
    assign Busy      = r_busy;

endmodule
